npu_mmio_array: RTL and testbench
=================================

# npu_mmio_array

Memory-mapped NPU compute array: a parametrised successor to the fixed 10-lane buffer/PE wrapper. It sits behind an axi2mem bridge on the 32-bit SRAM-like word port. It holds per-lane weights and inputs plus a shared broadcast input row, and runs a self-sequenced K×K signed MAC pass on all N lanes. Software reads results back through the same port and gets done/busy/error status plus an interrupt.

## Interface

Parameters:
- N_PE, 10: number of MAC lanes.
- K_SIZE, 3: kernel side; taps per pass KK = K_SIZE*K_SIZE.
- DATA_WIDTH, 8: signed operand width.
- ACC_WIDTH, 24: signed accumulator width. Must satisfy 2*DATA_WIDTH ≤ ACC_WIDTH ≤ AXI_WIDTH.
- AXI_WIDTH, 32: port word width.
- ADDR_W, 9: word-index width. Must satisfy 2^(ADDR_W-2) ≥ (N_PE+1)*KK.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- req_i  in  1  access qualifier.
- wen_i  in  4  write when req_i and any bit set; otherwise read when req_i.
- addr_i  in  ADDR_W  word index.
- wdata_i  in  AXI_WIDTH  write data.
- rdata_o  out  AXI_WIDTH  registered read data.
- irq_o  out  1  done interrupt.

## Operation

Address map: addr_i[ADDR_W-1:ADDR_W-2] selects the region; idx = addr_i[ADDR_W-3:0].
- Region 0, control:
  - idx0 CTRL (W): bit0 start, bit1 clear_done, bit2 bcast_mode, bit3 irq_en. Bits 2–3 are stored; bits 0–1 are pulses.
  - idx0 CTRL (R): returns stored bits 2–3.
  - idx1 STATUS (R): bit0 busy, bit1 done, bit2 err, bits[15:8] current tap.
  - Other idx: read 0.
- Region 1, weights: idx = pe*KK + tap. Stores wdata_i[DATA_WIDTH-1:0]. Reads return that byte sign-extended.
- Region 2, inputs: idx < N_PE*KK is the per-lane input. idx in [N_PE*KK, (N_PE+1)*KK) is the broadcast row. Reads return the byte sign-extended.
- Region 3, results: idx < N_PE reads that lane's accumulator sign-extended to AXI_WIDTH; it is read-only.
- Out-of-range idx: reads return 0; writes are ignored.

FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE → CLEAR on start.
- CLEAR: one cycle; zeroes all accumulators and the product registers.
- RUN: tap counter runs 0..KK-1. Each cycle every lane registers product w[pe][tap]*x, where x = bcast[tap] if bcast_mode else in[pe][tap].
- RUN → DRAIN after tap KK-1. DRAIN accumulates the last product.
- DONE: one cycle; sets done, then returns to IDLE.
- busy = state ≠ IDLE.

Arithmetic:
- Signed DATA_WIDTH × DATA_WIDTH gives a 2*DATA_WIDTH product.
- The product is sign-extended to ACC_WIDTH. Accumulation wraps modulo 2^ACC_WIDTH.

Boundary rules:
- start while busy: ignored; err set.
- Weight/input write while busy: ignored; err set.
- bcast_mode write while busy: ignored; err set.
- clear_done clears done and err.
- start and clear_done in the same write: clear first, then start.
- done stays set until clear_done or the next start. A new start clears done.
- Results are readable while busy and return the partial accumulator.
- irq_o = done & irq_en, registered.
- Reset mid-operation returns immediately to IDLE and clears everything.

## Timing

Reset values:
- All buffers, accumulators and CTRL bits: 0.
- rdata_o = 0, irq_o = 0, state IDLE.

Reads:
- A read at edge c presents data on rdata_o after edge c (1-cycle latency).
- The value is the register state before edge c's updates.
- rdata_o holds its value when there is no read.

Start/run sequence, with start written at edge t:
- CLEAR occupies cycle t+1.
- RUN occupies t+2..t+1+KK.
- DRAIN occupies t+2+KK.
- DONE occupies t+3+KK; done=1 is visible from edge t+3+KK onward.
- irq_o rises one edge later.
- For K_SIZE=3: busy covers t+1..t+12, done is visible from t+12, irq_o rises at t+13.
- A back-to-back start is accepted from the first IDLE cycle.

## Structure

- npu_pkg: state enum, region codes, CTRL/STATUS bit positions, and localparam functions for KK and region bounds.
- Sub-module npu_mac_lane, instantiated N_PE times: signed product register, accumulator, synchronous clear, enable. The top holds the register map, buffers, FSM and read mux.

## Test plan

- Reset, then read STATUS, CTRL and result[0]: all 0x00000000; irq_o = 0.
- Per-lane mode:
  - Stimulus: PE0 weights all 1, inputs 1..9; PE1 weights 0xFF, inputs 2; then start.
  - Response: result[0] = 45, result[1] = 0xFFFFFFEE; done at t+12.
- Broadcast mode: bcast row all 3, PE i weights all i, start → result[i] = 27*i for i = 0..9.
- Wrap: ACC_WIDTH=16, PE0 weights and inputs all 0x80 (-128) → result[0] = 0x00004000 (147456 mod 65536).
- Error path:
  - Stimulus: start; at t+4 write weight 5 and write start.
  - Response: STATUS err=1; final results match the original data. clear_done then reads STATUS = 0.
- Interrupt and reset:
  - With irq_en=1, irq_o rises at t+13 and clear_done drops it next edge.
  - Async rst_n low at t+5 → busy=0, results read 0, no irq.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared definitions for the memory-mapped NPU MAC array: FSM states, register
// map codes, CTRL/STATUS bit positions and sizing helpers.
package npu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_WGT  = 2'd1;
  localparam logic [1:0] REG_INP  = 2'd2;
  localparam logic [1:0] REG_RES  = 2'd3;

  localparam logic [1:0] IDX_CTRL   = 2'd0;
  localparam logic [1:0] IDX_STATUS = 2'd1;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_CLR_DONE = 1;
  localparam int unsigned CTRL_BCAST    = 2;
  localparam int unsigned CTRL_IRQ_EN   = 3;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_ERR     = 2;
  localparam int unsigned STAT_TAP_LSB = 8;

  function automatic int unsigned kk_f(input int unsigned k);
    return k * k;
  endfunction

  // Number of words in the weight region (per-lane taps).
  function automatic int unsigned wgt_words_f(input int unsigned n, input int unsigned k);
    return n * k * k;
  endfunction

  // Number of words in the input region (per-lane taps plus the broadcast row).
  function automatic int unsigned inp_words_f(input int unsigned n, input int unsigned k);
    return (n + 1) * k * k;
  endfunction

  // Index width that never collapses to zero bits for single-entry arrays.
  function automatic int unsigned idx_bits_f(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/npu_mac_lane.sv
// One signed MAC lane: registered product of weight and input, accumulated with
// wrap-around into an ACC_WIDTH accumulator.
module npu_mac_lane #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  mul_en_i,
  input  logic                  acc_en_i,
  input  logic [DATA_WIDTH-1:0] w_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;

  logic signed [PROD_W-1:0] prod_d, prod_q;
  logic [ACC_WIDTH-1:0]     acc_d, acc_q;

  assign prod_d = $signed(w_i) * $signed(x_i);
  assign acc_d  = acc_q + ACC_WIDTH'(prod_q);

  // Clear has priority so a new pass never sees stale products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else if (clr_i) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      if (mul_en_i) prod_q <= prod_d;
      if (acc_en_i) acc_q  <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/npu_mmio_array.sv
// Memory-mapped NPU compute array: register map, operand buffers, pass sequencer
// and registered read mux in front of N_PE signed MAC lanes.
module npu_mmio_array
  import npu_pkg::*;
#(
  parameter int unsigned N_PE       = 10,
  parameter int unsigned K_SIZE     = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned AXI_WIDTH  = 32,
  parameter int unsigned ADDR_W     = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_i,
  input  logic [3:0]           wen_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [AXI_WIDTH-1:0] wdata_i,
  output logic [AXI_WIDTH-1:0] rdata_o,
  output logic                 irq_o
);

  localparam int unsigned KK      = kk_f(K_SIZE);
  localparam int unsigned N_W     = wgt_words_f(N_PE, K_SIZE);
  localparam int unsigned N_I     = inp_words_f(N_PE, K_SIZE);
  localparam int unsigned IDX_W   = ADDR_W - 2;
  localparam int unsigned TAP_W   = idx_bits_f(KK);
  localparam int unsigned W_IDX_W = idx_bits_f(N_W);
  localparam int unsigned I_IDX_W = idx_bits_f(N_I);
  localparam int unsigned R_IDX_W = idx_bits_f(N_PE);

  state_e state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic done_q, done_d, err_q, err_d;
  logic bcast_q, bcast_d, irq_en_q, irq_en_d;
  logic irq_q;
  logic [AXI_WIDTH-1:0] rdata_q, rdata_c;

  logic [DATA_WIDTH-1:0] wgt_q [N_W];
  logic [DATA_WIDTH-1:0] inp_q [N_I];
  logic [ACC_WIDTH-1:0]  acc_c [N_PE];

  logic [1:0]         region_c;
  logic [IDX_W-1:0]   idx_c;
  logic               wr_c, rd_c, busy_c, ctrl_wr_c, start_c;
  logic               in_w_c, in_i_c, in_r_c, buf_wr_c;
  logic               lane_clr_c, mul_en_c, acc_en_c;
  logic [W_IDX_W-1:0] w_idx_c;
  logic [I_IDX_W-1:0] i_idx_c;
  logic [R_IDX_W-1:0] r_idx_c;
  logic               unused_c;

  assign region_c  = addr_i[ADDR_W-1:ADDR_W-2];
  assign idx_c     = addr_i[ADDR_W-3:0];
  assign wr_c      = req_i & (|wen_i);
  assign rd_c      = req_i & ~(|wen_i);
  assign busy_c    = (state_q != ST_IDLE);
  assign in_w_c    = (32'(idx_c) < N_W);
  assign in_i_c    = (32'(idx_c) < N_I);
  assign in_r_c    = (32'(idx_c) < N_PE);
  assign w_idx_c   = W_IDX_W'(idx_c);
  assign i_idx_c   = I_IDX_W'(idx_c);
  assign r_idx_c   = R_IDX_W'(idx_c);
  assign ctrl_wr_c = wr_c && (region_c == REG_CTRL) && (idx_c == IDX_W'(IDX_CTRL));
  assign start_c   = ctrl_wr_c && wdata_i[CTRL_START];
  assign buf_wr_c  = wr_c && (((region_c == REG_WGT) && in_w_c) ||
                              ((region_c == REG_INP) && in_i_c));
  assign unused_c  = ^wdata_i[AXI_WIDTH-1:DATA_WIDTH];

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tap_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      bcast_q  <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      done_q   <= done_d;
      err_q    <= err_d;
      bcast_q  <= bcast_d;
      irq_en_q <= irq_en_d;
      irq_q    <= done_q & irq_en_q;
    end
  end

  // Next-state, control-register updates and lane strobes.
  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    done_d     = done_q;
    err_d      = err_q;
    bcast_d    = bcast_q;
    irq_en_d   = irq_en_q;
    lane_clr_c = 1'b0;
    mul_en_c   = 1'b0;
    acc_en_c   = 1'b0;

    // clear_done is applied before start so a combined write restarts cleanly.
    if (ctrl_wr_c) begin
      if (wdata_i[CTRL_CLR_DONE]) begin
        done_d = 1'b0;
        err_d  = 1'b0;
      end
      irq_en_d = wdata_i[CTRL_IRQ_EN];
      if (!busy_c)                              bcast_d = wdata_i[CTRL_BCAST];
      else if (wdata_i[CTRL_BCAST] != bcast_q) err_d   = 1'b1;
    end
    if (buf_wr_c && busy_c) err_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d = ST_CLEAR;
          done_d  = 1'b0;
        end
      end
      ST_CLEAR: begin
        lane_clr_c = 1'b1;
        tap_d      = '0;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        mul_en_c = 1'b1;
        acc_en_c = 1'b1;
        if (tap_q == TAP_W'(KK - 1)) begin
          tap_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
      ST_DRAIN: begin
        acc_en_c = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_c && busy_c) err_d = 1'b1;
  end

  // Operand buffers are frozen while a pass is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_W; i++) wgt_q[i] <= '0;
      for (int i = 0; i < N_I; i++) inp_q[i] <= '0;
    end else if (wr_c && !busy_c) begin
      if ((region_c == REG_WGT) && in_w_c) wgt_q[w_idx_c] <= wdata_i[DATA_WIDTH-1:0];
      if ((region_c == REG_INP) && in_i_c) inp_q[i_idx_c] <= wdata_i[DATA_WIDTH-1:0];
    end
  end

  for (genvar p = 0; p < N_PE; p++) begin : g_lane
    logic [DATA_WIDTH-1:0] w_c, x_c;

    assign w_c = wgt_q[W_IDX_W'(p * KK) + W_IDX_W'(tap_q)];
    assign x_c = bcast_q ? inp_q[I_IDX_W'(N_W) + I_IDX_W'(tap_q)]
                         : inp_q[I_IDX_W'(p * KK) + I_IDX_W'(tap_q)];

    npu_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (lane_clr_c),
      .mul_en_i (mul_en_c),
      .acc_en_i (acc_en_c),
      .w_i      (w_c),
      .x_i      (x_c),
      .acc_o    (acc_c[p])
    );
  end

  // Read mux over the pre-edge register state.
  always_comb begin
    rdata_c = '0;
    unique case (region_c)
      REG_CTRL: begin
        if (idx_c == IDX_W'(IDX_CTRL)) begin
          rdata_c[CTRL_BCAST]  = bcast_q;
          rdata_c[CTRL_IRQ_EN] = irq_en_q;
        end else if (idx_c == IDX_W'(IDX_STATUS)) begin
          rdata_c[STAT_BUSY]                = busy_c;
          rdata_c[STAT_DONE]                = done_q;
          rdata_c[STAT_ERR]                 = err_q;
          rdata_c[STAT_TAP_LSB +: TAP_W]    = tap_q;
        end
      end
      REG_WGT: if (in_w_c) rdata_c = AXI_WIDTH'($signed(wgt_q[w_idx_c]));
      REG_INP: if (in_i_c) rdata_c = AXI_WIDTH'($signed(inp_q[i_idx_c]));
      REG_RES: if (in_r_c) rdata_c = AXI_WIDTH'($signed(acc_c[r_idx_c]));
      default: rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (rd_c) rdata_q <= rdata_c;
  end

  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_npu_mmio_array.sv
// Directed bench for npu_mmio_array: default instance plus a 16-bit accumulator
// instance for the wrap case, driven on negedges and sampled half a cycle later.
module tb_npu_mmio_array;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [3:0]  wen;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata0, rdata1;
  logic        irq0, irq1;

  int n_checks = 0;
  int n_errors = 0;

  npu_mmio_array u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req0),
    .wen_i   (wen),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata0),
    .irq_o   (irq0)
  );

  npu_mmio_array #(.ACC_WIDTH(16)) u_dut16 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req1),
    .wen_i   (wen),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata1),
    .irq_o   (irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Both bus tasks are entered on a negedge and return on the next negedge.
  task automatic bus_write(input logic sel, input logic [1:0] rg, input int idx,
                           input logic [31:0] d);
    addr  = {rg, 7'(idx)};
    wdata = d;
    wen   = 4'hF;
    if (sel) req1 = 1'b1; else req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    wen  = 4'h0;
  endtask

  task automatic bus_read(input logic sel, input logic [1:0] rg, input int idx,
                          output logic [31:0] d);
    addr = {rg, 7'(idx)};
    wen  = 4'h0;
    if (sel) req1 = 1'b1; else req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    d = sel ? rdata1 : rdata0;
  endtask

  logic [31:0] rd;

  initial begin
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    wen   = 4'h0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    bus_read(0, 2'd0, 1, rd); check("reset_status", rd, 32'h0);
    bus_read(0, 2'd0, 0, rd); check("reset_ctrl", rd, 32'h0);
    bus_read(0, 2'd3, 0, rd); check("reset_res0", rd, 32'h0);
    check("reset_irq", {31'h0, irq0}, 32'h0);

    // Per-lane pass: PE0 w=1 x=1..9, PE1 w=-1 x=2.
    for (int t = 0; t < 9; t++) begin
      bus_write(0, 2'd1, t, 32'h1);
      bus_write(0, 2'd2, t, 32'(t + 1));
      bus_write(0, 2'd1, 9 + t, 32'hFF);
      bus_write(0, 2'd2, 9 + t, 32'h2);
    end
    bus_read(0, 2'd1, 9, rd); check("wgt_sext", rd, 32'hFFFF_FFFF);
    bus_write(0, 2'd0, 0, 32'h1);
    repeat (11) @(negedge clk);
    bus_read(0, 2'd0, 1, rd); check("status_t12", rd, 32'h1);
    bus_read(0, 2'd0, 1, rd); check("status_t13", rd, 32'h2);
    bus_read(0, 2'd3, 0, rd); check("lane_res0", rd, 32'd45);
    bus_read(0, 2'd3, 1, rd); check("lane_res1", rd, 32'hFFFF_FFEE);
    bus_read(0, 2'd3, 2, rd); check("lane_res2", rd, 32'h0);

    // Wrap on the 16-bit accumulator instance.
    for (int t = 0; t < 9; t++) begin
      bus_write(1, 2'd1, t, 32'h80);
      bus_write(1, 2'd2, t, 32'h80);
    end
    bus_read(1, 2'd2, 0, rd); check("inp_sext16", rd, 32'hFFFF_FF80);
    bus_write(1, 2'd0, 0, 32'h1);
    repeat (14) @(negedge clk);
    bus_read(1, 2'd3, 0, rd); check("wrap_res0", rd, 32'h0000_4000);
    check("wrap_no_irq", {31'h0, irq1}, 32'h0);

    // Broadcast pass: row of 3s, PE i weights all i.
    bus_write(0, 2'd0, 0, 32'h4);
    bus_read(0, 2'd0, 0, rd); check("ctrl_bcast", rd, 32'h4);
    for (int t = 0; t < 9; t++) begin
      bus_write(0, 2'd2, 90 + t, 32'h3);
      for (int p = 0; p < 10; p++) bus_write(0, 2'd1, p * 9 + t, 32'(p));
    end
    bus_write(0, 2'd0, 0, 32'h5);
    repeat (14) @(negedge clk);
    bus_read(0, 2'd0, 1, rd); check("bcast_status", rd, 32'h2);
    for (int p = 0; p < 10; p++) begin
      bus_read(0, 2'd3, p, rd);
      check($sformatf("bcast_res%0d", p), rd, 32'(27 * p));
    end
    bus_read(0, 2'd3, 10, rd); check("res_oor", rd, 32'h0);

    // Error path: weight write and second start while busy.
    bus_write(0, 2'd0, 0, 32'h5);
    repeat (3) @(negedge clk);
    bus_write(0, 2'd1, 18, 32'h5);
    bus_write(0, 2'd0, 0, 32'h5);
    repeat (12) @(negedge clk);
    bus_read(0, 2'd0, 1, rd); check("err_status", rd, 32'h6);
    bus_read(0, 2'd3, 2, rd); check("err_res2", rd, 32'd54);
    bus_read(0, 2'd1, 18, rd); check("err_wgt_kept", rd, 32'h2);
    bus_write(0, 2'd0, 0, 32'h6);
    bus_read(0, 2'd0, 1, rd); check("err_cleared", rd, 32'h0);

    // Interrupt timing.
    bus_write(0, 2'd0, 0, 32'hD);
    repeat (12) @(negedge clk);
    check("irq_t12", {31'h0, irq0}, 32'h0);
    @(negedge clk);
    check("irq_t13", {31'h0, irq0}, 32'h1);
    bus_write(0, 2'd0, 0, 32'hE);
    check("irq_hold", {31'h0, irq0}, 32'h1);
    @(negedge clk);
    check("irq_drop", {31'h0, irq0}, 32'h0);

    // Asynchronous reset in the middle of a pass.
    bus_write(0, 2'd0, 0, 32'h9);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(0, 2'd0, 1, rd); check("rst_status", rd, 32'h0);
    bus_read(0, 2'd3, 2, rd); check("rst_res2", rd, 32'h0);
    bus_read(0, 2'd0, 0, rd); check("rst_ctrl", rd, 32'h0);
    repeat (15) @(negedge clk);
    check("rst_no_irq", {31'h0, irq0}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
